// File: rtl/echo_pipe_tx.sv
// 96-bit message to 3 x 32-bit word serializer, low word first.
// Optional ECHO_PIPE_TX_DBUF_EN adds a second message buffer for gapless back-to-back sends.
module echo_pipe_tx #(
   parameter int unsigned WORDS = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 enq__ENA,
   input  logic [95:0]          enq_v,
   output logic                 enq__RDY,
   output logic                 word__ENA,
   output logic [31:0]          word_v,
   output logic                 word_last,
   input  logic                 word__RDY,
   output logic [CNT_W-1:0]     msg_count
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned MSG_W  = WORDS * WORD_W;
   localparam logic [1:0]  LAST_BEAT = 2'(WORDS - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]       state, state_nx;
   logic [1:0]       beat, beat_nx;
   logic [MSG_W-1:0] hold, hold_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             busy, xfer, at_last, accept;

`ifdef ECHO_PIPE_TX_DBUF_EN
   logic [MSG_W-1:0] next_q, next_q_nx;
   logic             next_vld, next_vld_nx;
`endif

   assign busy    = (state == S_SEND);
   assign at_last = (beat == LAST_BEAT);
   assign xfer    = !nRST && busy && word__RDY;

`ifdef ECHO_PIPE_TX_DBUF_EN
   assign enq__RDY = !nRST && !next_vld;
`else
   assign enq__RDY = !nRST && !busy;
`endif

   assign accept    = enq__ENA && enq__RDY;
   assign word__ENA = xfer;
   assign word_last = !nRST && busy && at_last;
   assign word_v    = hold[WORD_W*32'(beat) +: WORD_W];
   assign msg_count = cnt;

   // Next-state and datapath updates
   always_comb begin
      state_nx = state;
      beat_nx  = beat;
      hold_nx  = hold;
      cnt_nx   = cnt;
`ifdef ECHO_PIPE_TX_DBUF_EN
      next_q_nx   = next_q;
      next_vld_nx = next_vld;
`endif
      case (state)
         S_IDLE: begin
            if (accept) begin
               hold_nx  = enq_v;
               beat_nx  = 2'd0;
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            if (xfer) begin
               if (at_last) begin
                  cnt_nx  = cnt + CNT_W'(1);
                  beat_nx = 2'd0;
`ifdef ECHO_PIPE_TX_DBUF_EN
                  if (next_vld) begin
                     hold_nx     = next_q;
                     next_vld_nx = 1'b0;
                  end else if (accept) begin
                     hold_nx = enq_v;
                  end else begin
                     state_nx = S_IDLE;
                  end
`else
                  state_nx = S_IDLE;
`endif
               end else begin
                  beat_nx = beat + 2'd1;
               end
            end
`ifdef ECHO_PIPE_TX_DBUF_EN
            // A message arriving as hold empties goes straight to hold above
            if (accept && !(xfer && at_last)) begin
               next_q_nx   = enq_v;
               next_vld_nx = 1'b1;
            end
`endif
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         state <= S_IDLE;
         beat  <= 2'd0;
         cnt   <= '0;
`ifdef ECHO_PIPE_TX_DBUF_EN
         next_vld <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         beat  <= beat_nx;
         hold  <= hold_nx;
         cnt   <= cnt_nx;
`ifdef ECHO_PIPE_TX_DBUF_EN
         next_q   <= next_q_nx;
         next_vld <= next_vld_nx;
`endif
      end
   end

endmodule

// File: tb/tb_echo_pipe_tx.sv
// Randomized and directed bench for echo_pipe_tx against a beat-queue reference model.
module tb_echo_pipe_tx;

   localparam int unsigned CW = 4;
`ifdef ECHO_PIPE_TX_DBUF_EN
   localparam int DEPTH = 3;
`else
   localparam int DEPTH = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          enq_en;
   logic [95:0]   enq_d;
   logic          enq_rdy;
   logic          w_ena;
   logic [31:0]   w_v;
   logic          w_last;
   logic          w_rdy;
   logic [CW-1:0] cnt;

   always #5 clk = ~clk;

   echo_pipe_tx #(.WORDS(3), .CNT_W(CW)) dut (
      .CLK(clk), .nRST(rst),
      .enq__ENA(enq_en), .enq_v(enq_d), .enq__RDY(enq_rdy),
      .word__ENA(w_ena), .word_v(w_v), .word_last(w_last), .word__RDY(w_rdy),
      .msg_count(cnt)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        last;
   } beat_t;

   beat_t         q[$];
   logic [CW-1:0] m_cnt;
   logic [31:0]   got[$];
   int            vectors = 0;
   int            errors  = 0;
   int            cyc     = 0;
   int            first_beat_cyc;
   int            last_beat_cyc;
   int            sent;

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_ready();
      return q.size() <= DEPTH;
   endfunction

   // One clock: drive, compare at negedge, advance the model, move past posedge
   task automatic step(input logic e, input logic [95:0] d, input logic wr, input logic r);
      bit    rdy;
      beat_t b;
      rst = r; enq_en = e; enq_d = d; w_rdy = wr;
      @(negedge clk);
      rdy = !r && m_ready();
      check1("enq_rdy", 32'(enq_rdy), 32'(rdy));
      check1("word_ena", 32'(w_ena), 32'(!r && q.size() > 0 && wr));
      check1("word_last", 32'(w_last), 32'(!r && q.size() > 0 && q[0].last));
      if (!r && q.size() > 0) check1("word_v", w_v, q[0].d);
      check1("msg_count", 32'(cnt), 32'(m_cnt));
      if (w_ena === 1'b1) begin
         got.push_back(w_v);
         last_beat_cyc = cyc;
         if (first_beat_cyc < 0) first_beat_cyc = cyc;
      end
      if (r) begin
         q.delete();
         m_cnt = '0;
      end else begin
         if (q.size() > 0 && wr) begin
            b = q.pop_front();
            if (b.last) m_cnt = m_cnt + CW'(1);
         end
         if (e && rdy) begin
            for (int i = 0; i < 3; i++) begin
               b.d    = d[32*i +: 32];
               b.last = (i == 2);
               q.push_back(b);
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b1);
   endtask

   // Send n random messages, enq whenever the model says the block is ready
   task automatic burst(input int n, input int max_cyc);
      bit e;
      sent = 0;
      for (int i = 0; i < max_cyc; i++) begin
         if (sent == n && q.size() == 0) break;
         e = (sent < n) && m_ready();
         if (e) sent++;
         step(e, {$urandom, $urandom, $urandom}, 1'b1, 1'b0);
      end
   endtask

   localparam logic [95:0] MSG_A = 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [95:0] MSG_D = 96'h33333333_22222222_11111111;
   localparam logic [95:0] MSG_X = 96'h99999999_88888888_77777777;

   int start_cyc;
   int enq_cyc;
   logic [3:0] wpat;

   initial begin
      rst = 1'b1; enq_en = 1'b0; enq_d = '0; w_rdy = 1'b1;
      m_cnt = '0;
      first_beat_cyc = -1;
      last_beat_cyc  = -1;
      @(posedge clk);
      #1;

      // Single message after reset
      do_reset(2);
      got.delete(); first_beat_cyc = -1;
      enq_cyc = cyc;
      step(1'b1, MSG_A, 1'b1, 1'b0);
      idle(4);
      check1("single_n", 32'(got.size()), 32'd3);
      check1("single_w0", got[0], 32'hAAAAAAAA);
      check1("single_w1", got[1], 32'hBBBBBBBB);
      check1("single_w2", got[2], 32'hCCCCCCCC);
      check1("single_lat", 32'(first_beat_cyc - enq_cyc), 32'd1);
      check1("single_cnt", 32'(cnt), 32'd1);

      // Backpressure 1,0,0,1,0,1
      got.delete();
      step(1'b1, MSG_A, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      idle(2);
      check1("bp_n", 32'(got.size()), 32'd3);
      check1("bp_w0", got[0], 32'hAAAAAAAA);
      check1("bp_w2", got[2], 32'hCCCCCCCC);
      check1("bp_cnt", 32'(cnt), 32'd2);

      // Back-to-back, 4 messages
      got.delete(); first_beat_cyc = -1;
      start_cyc = cyc;
      burst(4, 40);
      idle(1);
      check1("b2b_n", 32'(got.size()), 32'd12);
      check1("b2b_cnt", 32'(cnt), 32'd6);
`ifdef ECHO_PIPE_TX_DBUF_EN
      check1("b2b_window", 32'(last_beat_cyc - start_cyc + 1), 32'd13);
      check1("b2b_span", 32'(last_beat_cyc - first_beat_cyc + 1), 32'd12);
`else
      check1("b2b_window", 32'(last_beat_cyc - start_cyc + 1), 32'd16);
      check1("b2b_span", 32'(last_beat_cyc - first_beat_cyc + 1), 32'd15);
`endif

      // Reset after beat1, then a clean message
      do_reset(1);
      got.delete();
      step(1'b1, MSG_A, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      do_reset(1);
      idle(3);
      check1("rst_n", 32'(got.size()), 32'd2);
      check1("rst_cnt", 32'(cnt), 32'd0);
      step(1'b1, MSG_D, 1'b1, 1'b0);
      idle(4);
      check1("rst_next_n", 32'(got.size()), 32'd5);
      check1("rst_next_w0", got[2], 32'h11111111);
      check1("rst_next_w2", got[4], 32'h33333333);
      check1("rst_next_cnt", 32'(cnt), 32'd1);

      // Counter wrap at 2^CW
      do_reset(1);
      burst(17, 17 * 4 + 10);
      idle(1);
      check1("wrap_cnt", 32'(cnt), 32'd1);

      // enq pulsed while sending
      do_reset(1);
      got.delete();
      step(1'b1, MSG_A, 1'b1, 1'b0);
      step(1'b1, MSG_X, 1'b1, 1'b0);
      idle(8);
`ifndef ECHO_PIPE_TX_DBUF_EN
      check1("illegal_n", 32'(got.size()), 32'd3);
      check1("illegal_w1", got[1], 32'hBBBBBBBB);
      check1("illegal_cnt", 32'(cnt), 32'd1);
`else
      check1("dbuf_n", 32'(got.size()), 32'd6);
      check1("dbuf_w3", got[3], 32'h77777777);
      check1("dbuf_cnt", 32'(cnt), 32'd2);
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         wpat = 4'($urandom_range(0, 15));
         step($urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom},
              wpat < 4'd11, $urandom_range(0, 99) == 0);
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
